// File: rtl/serial_alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: opcodes, FSM encodings, helpers.
package serial_alu_ctrl_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_AND  = 3'b000;
    localparam alu_op_t OP_OR   = 3'b001;
    localparam alu_op_t OP_XOR  = 3'b010;
    localparam alu_op_t OP_NAND = 3'b011;
    localparam alu_op_t OP_NOT  = 3'b100;
    localparam alu_op_t OP_ADD  = 3'b101;
    localparam alu_op_t OP_SUB  = 3'b110;
    localparam alu_op_t OP_PASS = 3'b111;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Only ADD/SUB propagate a carry between bit slices.
    function automatic logic is_arith(input alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Request/result handshake bundle between a requester and the serial ALU sequencer.
interface serial_alu_ctrl_if
    import serial_alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    alu_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             zero;

    modport master (output start, op, a, b, input busy, done, y, cout, zero);
    modport slave  (input start, op, a, b, output busy, done, y, cout, zero);
endinterface

// File: rtl/AND2.sv
// Library gate cell: 2-input AND.
module AND2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

// File: rtl/EXOR2.sv
// Library gate cell: 2-input XOR.
module EXOR2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// File: rtl/NAND2.sv
// Library gate cell: 2-input NAND.
module NAND2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

// File: rtl/NOT1.sv
// Library gate cell: inverter.
module NOT1 (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

// File: rtl/OR2.sv
// Library gate cell: 2-input OR.
module OR2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

// File: rtl/serial_alu_ctrl_alu_bit.sv
// Combinational 1-bit ALU slice built from library gate cells; full adder from XOR/AND/OR.
module serial_alu_ctrl_alu_bit
    import serial_alu_ctrl_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    cin,
    input  alu_op_t op,
    output logic    r,
    output logic    cout
);
    logic and_ab, or_ab, xor_ab, nand_ab, not_a, sum, prop_c;

    AND2  u_and  (.a(a),      .b(b),   .y(and_ab));
    OR2   u_or   (.a(a),      .b(b),   .y(or_ab));
    EXOR2 u_xor  (.a(a),      .b(b),   .y(xor_ab));
    NAND2 u_nand (.a(a),      .b(b),   .y(nand_ab));
    NOT1  u_not  (.a(a),                .y(not_a));

    // Full adder: sum = a^b^cin, cout = a&b | (a^b)&cin
    EXOR2 u_sum  (.a(xor_ab), .b(cin), .y(sum));
    AND2  u_prop (.a(xor_ab), .b(cin), .y(prop_c));
    OR2   u_cout (.a(and_ab), .b(prop_c), .y(cout));

    always_comb begin
        r = 1'b0;
        case (op)
            OP_AND:         r = and_ab;
            OP_OR:          r = or_ab;
            OP_XOR:         r = xor_ab;
            OP_NAND:        r = nand_ab;
            OP_NOT:         r = not_a;
            OP_ADD, OP_SUB: r = sum;
            OP_PASS:        r = a;
            default:        r = 1'b0;
        endcase
    end
endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: shifts operands LSB-first through one ALU slice, one bit per clock.
module serial_alu_ctrl
    import serial_alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
)(
    input  logic            clk,
    input  logic            rst_n,
    serial_alu_ctrl_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [0:0]       state_q, state_d;
    alu_op_t          op_q, op_d;
    logic [WIDTH-1:0] a_sr, a_d, b_sr, b_d, r_sr, r_d, y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d, done_q, done_d, cout_q, cout_d, zero_q, zero_d;

    logic             b_bit, bit_r, bit_cout;
    logic [WIDTH-1:0] r_next;

    // Subtraction is a + ~b + 1: invert b here, the +1 comes from the preloaded carry.
    assign b_bit  = (op_q == OP_SUB) ? ~b_sr[0] : b_sr[0];
    assign r_next = {bit_r, r_sr[WIDTH-1:1]};

    serial_alu_ctrl_alu_bit u_bit (
        .a    (a_sr[0]),
        .b    (b_bit),
        .cin  (carry_q),
        .op   (op_q),
        .r    (bit_r),
        .cout (bit_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_AND;
            a_sr    <= '0;
            b_sr    <= '0;
            r_sr    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_sr    <= a_d;
            b_sr    <= b_d;
            r_sr    <= r_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_sr;
        b_d     = b_sr;
        r_d     = r_sr;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        y_d     = y_q;
        cout_d  = cout_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    r_d     = '0;
                    cnt_d   = '0;
                    carry_d = (bus.op == OP_SUB);
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                a_d   = {1'b0, a_sr[WIDTH-1:1]};
                b_d   = {1'b0, b_sr[WIDTH-1:1]};
                r_d   = r_next;
                cnt_d = cnt_q + CW'(1);
                if (is_arith(op_q)) carry_d = bit_cout;
                // Last bit: publish the result and return to idle.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    y_d     = r_next;
                    cout_d  = is_arith(op_q) & bit_cout;
                    zero_d  = (r_next == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.y    = y_q;
    assign bus.cout = cout_q;
    assign bus.zero = zero_q;
endmodule
